// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with registered result and flags.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] MUL  = 2'd1;
`endif

  logic [1:0] state;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic [SW-1:0]    sh;

  assign sh = b[SW-1:0];

  // SUB reuses the adder as a + ~b + 1
  always_comb begin
    sub     = (sel == 3'b011);
    bx      = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (sel)
      3'b000: res_c = a & b;
      3'b001: res_c = a | b;
      3'b010, 3'b011: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (a[WIDTH-1] == bx[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: res_c = {{(WIDTH-1){1'b0}},
                       ($signed(a) < $signed(b))};
      3'b101: res_c = a << sh;
      3'b110: res_c = $signed(a) >>> sh;
      default: res_c = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [SW-1:0]    cnt;

  assign acc_nx = acc + (mb[0] ? ma : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (sel == 3'b111) begin
              ma    <= a;
              mb    <= b;
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              result <= res_c;
              zero   <= (res_c == '0);
              neg    <= res_c[WIDTH-1];
              carry  <= carry_c;
              ovf    <= ovf_c;
              state  <= DONE;
            end
`else
            result <= res_c;
            zero   <= (res_c == '0);
            neg    <= res_c[WIDTH-1];
            carry  <= carry_c;
            ovf    <= ovf_c;
            state  <= DONE;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          acc <= acc_nx;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
          // last multiplier bit: commit the low product bits
          if (cnt == SW'(WIDTH - 1)) begin
            result <= acc_nx;
            zero   <= (acc_nx == '0);
            neg    <= acc_nx[WIDTH-1];
            carry  <= 1'b0;
            ovf    <= 1'b0;
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Covers both builds of ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       neg;
  logic       carry;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for in_ready, then present one op for one edge
  task automatic accept(input logic [2:0] s,
                        input logic [7:0] av,
                        input logic [7:0] bv);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
    end
    sel      = s;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({in_ready, out_valid, result, zero, neg, carry, ovf} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h flags=%b%b%b%b required all 0",
               in_ready, out_valid, result, zero, neg, carry, ovf);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  // flags packed as {zero,neg,carry,ovf}
  task automatic test_arith();
    logic [2:0] vs [6] = '{3'b010, 3'b010, 3'b011, 3'b010, 3'b011, 3'b011};
    logic [7:0] va [6] = '{8'h0F, 8'hAA, 8'h0F, 8'hFF, 8'h5A, 8'h80};
    logic [7:0] vb [6] = '{8'h5A, 8'hBB, 8'h5A, 8'h01, 8'h0F, 8'h01};
    logic [7:0] vr [6] = '{8'h69, 8'h65, 8'hB5, 8'h00, 8'h4B, 8'h7F};
    logic [3:0] vf [6] = '{4'b0000, 4'b0011, 4'b0100, 4'b1010, 4'b0010, 4'b0011};
    for (int i = 0; i < 6; i++) begin
      accept(vs[i], va[i], vb[i]);
      n_checks++;
      if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, vr[i], vf[i]}) begin
        n_fail++;
        $display("FAIL arith_%0d got vld=%b res=%h zncv=%b%b%b%b required vld=1 res=%h zncv=%b",
                 i, out_valid, result, zero, neg, carry, ovf, vr[i], vf[i]);
      end
      release_out();
    end
  endtask

  task automatic test_logic_shift();
    logic [2:0] vs [7] = '{3'b000, 3'b001, 3'b100, 3'b100, 3'b110, 3'b101, 3'b101};
    logic [7:0] va [7] = '{8'hAA, 8'hAA, 8'hAA, 8'h5A, 8'hAA, 8'hAA, 8'hAA};
    logic [7:0] vb [7] = '{8'hF0, 8'h55, 8'h5A, 8'hAA, 8'hBB, 8'hF0, 8'h03};
    logic [7:0] vr [7] = '{8'hA0, 8'hFF, 8'h01, 8'h00, 8'hF5, 8'hAA, 8'h50};
    logic [3:0] vf [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      accept(vs[i], va[i], vb[i]);
      n_checks++;
      if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, vr[i], vf[i]}) begin
        n_fail++;
        $display("FAIL logic_%0d got vld=%b res=%h zncv=%b%b%b%b required vld=1 res=%h zncv=%b",
                 i, out_valid, result, zero, neg, carry, ovf, vr[i], vf[i]);
      end
      release_out();
    end
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h10};
    logic [7:0] vb [3] = '{8'h5A, 8'hFF, 8'h10};
    logic [7:0] vr [3] = '{8'h46, 8'h01, 8'h00};
    logic [3:0] vf [3] = '{4'b0000, 4'b0000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      accept(3'b111, va[i], vb[i]);
      for (int c = 1; c < 8; c++) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mul_busy_%0d_%0d rdy=%b vld=%b required 0 0",
                   i, c, in_ready, out_valid);
        end
        step();
      end
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_busy_%0d_8 rdy=%b vld=%b required 0 0",
                 i, in_ready, out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, vr[i], vf[i]}) begin
        n_fail++;
        $display("FAIL mul_%0d got vld=%b res=%h zncv=%b%b%b%b required vld=1 res=%h zncv=%b",
                 i, out_valid, result, zero, neg, carry, ovf, vr[i], vf[i]);
      end
      release_out();
    end
`else
    accept(3'b111, 8'h0F, 8'h5A);
    n_checks++;
    if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, 8'h00, 4'b1000}) begin
      n_fail++;
      $display("FAIL mul_off got vld=%b res=%h zncv=%b%b%b%b required vld=1 res=00 zncv=1000",
               out_valid, result, zero, neg, carry, ovf);
    end
    release_out();
`endif
  endtask

  task automatic test_backpressure();
    accept(3'b011, 8'h0F, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sel      = 3'(i);
      a        = 8'(8'h11 * i);
      b        = 8'(8'h33 + i);
      step();
      n_checks++;
      if ({in_ready, out_valid, result, zero, neg, carry, ovf} !==
          {1'b0, 1'b1, 8'hB5, 4'b0100}) begin
        n_fail++;
        $display("FAIL hold_%0d got rdy=%b vld=%b res=%h zncv=%b%b%b%b required rdy=0 vld=1 res=b5 zncv=0100",
                 i, in_ready, out_valid, result, zero, neg, carry, ovf);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    accept(3'b010, 8'h01, 8'h02);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h03) begin
      n_fail++;
      $display("FAIL b2b_first vld=%b res=%h required 1 03", out_valid, result);
    end
    sel      = 3'b001;
    a        = 8'h30;
    b        = 8'h0C;
    in_valid = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_second vld=%b res=%h required 1 3c", out_valid, result);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
`ifdef ALU_SEQ_MUL_EN
    accept(3'b111, 8'h0F, 8'h5A);
    step();
    step();
    step();
`else
    accept(3'b011, 8'h0F, 8'h5A);
`endif
    rst = 1'b1;
    step();
    n_checks++;
    if ({in_ready, out_valid, result, zero, neg, carry, ovf} !== 13'h0) begin
      n_fail++;
      $display("FAIL mid_reset got rdy=%b vld=%b res=%h zncv=%b%b%b%b required all 0",
               in_ready, out_valid, result, zero, neg, carry, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL no_stale_%0d vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
      end
    end
    accept(3'b010, 8'h01, 8'h01);
    n_checks++;
    if ({out_valid, result, zero, neg, carry, ovf} !== {1'b1, 8'h02, 4'b0000}) begin
      n_fail++;
      $display("FAIL post_reset_add vld=%b res=%h zncv=%b%b%b%b required 1 02 0000",
               out_valid, result, zero, neg, carry, ovf);
    end
    release_out();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
